// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Debounces a raw, bouncing, active-high push button. The button passes
// through a two-flop synchronizer. A four-state FSM then requires the
// synchronized level to stay stable for DB_CYC consecutive cycles before it
// accepts a press or a release. Every accepted change produces a one-cycle
// strobe.
//
// Optional feature, controlled by the macro BTN_LONG_PRESS_EN:
//   defined   - long_pulse strobes once after a press has been held for
//               LONG_CYC cycles.
//   undefined - long_pulse is tied to 0 and no long-press counter is built.
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int CLK_HZ      = 125000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int CYC_PER_MS = CLK_HZ / 1000;
  localparam int DB_CYC     = CYC_PER_MS * DEBOUNCE_MS;
  localparam int DB_W       = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYC - 1);

`ifdef BTN_LONG_PRESS_EN
  localparam int LONG_CYC = CYC_PER_MS * LONG_MS;
  localparam int LONG_W   = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYC - 1);
`endif

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t          state;
  logic            btn_meta;
  logic            btn_sync;
  logic [DB_W-1:0] db_cnt;

`ifdef BTN_LONG_PRESS_EN
  logic [LONG_W-1:0] long_cnt;
  logic              long_done;
`endif

  // Two-flop synchronizer; btn_sync is the only view of the raw button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

  // Debounce FSM with the stable-time counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      db_cnt        <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
      long_cnt      <= '0;
      long_done     <= 1'b0;
      long_pulse    <= 1'b0;
`endif
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (btn_sync) begin
            state  <= PRESS_WAIT;
            db_cnt <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!btn_sync) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_cnt == DB_MAX) begin
            state       <= PRESSED;
            db_cnt      <= '0;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end

        PRESSED: begin
          if (!btn_sync) begin
            state  <= RELEASE_WAIT;
            db_cnt <= '0;
          end
        end

        RELEASE_WAIT: begin
          if (btn_sync) begin
            state  <= PRESSED;
            db_cnt <= '0;
          end else if (db_cnt == DB_MAX) begin
            state         <= IDLE;
            db_cnt        <= '0;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end

        default: begin
          state     <= IDLE;
          db_cnt    <= '0;
          btn_level <= 1'b0;
        end
      endcase

`ifdef BTN_LONG_PRESS_EN
      long_pulse <= 1'b0;
      if (state == PRESS_WAIT && btn_sync && db_cnt == DB_MAX) begin
        long_cnt  <= '0;
        long_done <= 1'b0;
      end else if (state == PRESSED) begin
        if (long_cnt == LONG_MAX) begin
          if (!long_done) begin
            long_pulse <= 1'b1;
            long_done  <= 1'b1;
          end
        end else begin
          long_cnt <= long_cnt + LONG_W'(1);
        end
      end
`endif
    end
  end

`ifndef BTN_LONG_PRESS_EN
  assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce
// Scoreboard bench for btn_debounce with DB_CYC=20 and LONG_CYC=100.
// The stimulus process pushes each expected strobe, together with the clock
// edge it must follow, into a queue. A monitor on the falling edge pops and
// compares every strobe the DUT raises. Directed level checks cover the
// boundary edges.
// ---------------------------------------------------------------------------
module tb_btn_debounce;

  localparam int DB_CYC   = 20;
  localparam int LONG_CYC = 100;

  logic clk = 1'b0;
  logic rst_n;
  logic btn;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  typedef struct {
    int kind;
    int edgeNum;
  } exp_t;

  exp_t expQ[$];
  int   edgeIdx   = 0;
  int   numChecks = 0;
  int   numErrors = 0;

  btn_debounce #(
    .CLK_HZ      (10000),
    .DEBOUNCE_MS (2),
    .LONG_MS     (10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn           (btn),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Count rising edges; the edge just taken has index edgeIdx-1 at negedge.
  always @(posedge clk) edgeIdx <= edgeIdx + 1;

  function automatic string kindName(input int k);
    case (k)
      0:       return "press_pulse";
      1:       return "release_pulse";
      default: return "long_pulse";
    endcase
  endfunction

  function automatic void pushExpect(input int k, input int e);
    exp_t x;
    x.kind    = k;
    x.edgeNum = e;
    expQ.push_back(x);
  endfunction

  task automatic matchStrobe(input int k);
    exp_t x;
    numChecks++;
    if (expQ.size() == 0) begin
      numErrors++;
      $display("[TB] FAIL unexpected_%s: seen after edge %0d, required none", kindName(k), edgeIdx - 1);
    end else begin
      x = expQ.pop_front();
      if (x.kind != k || x.edgeNum != edgeIdx - 1) begin
        numErrors++;
        $display("[TB] FAIL strobe_order: got %s after edge %0d, required %s after edge %0d",
                 kindName(k), edgeIdx - 1, kindName(x.kind), x.edgeNum);
      end
    end
  endtask

  // Monitor: outputs are quiet in reset; every strobe must match the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      numChecks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse} != 4'b0000) begin
        numErrors++;
        $display("[TB] FAIL outputs_in_reset: got %b, required 0000",
                 {btn_level, press_pulse, release_pulse, long_pulse});
      end
    end else begin
      if (press_pulse && release_pulse) begin
        numChecks++;
        numErrors++;
        $display("[TB] FAIL both_strobes: press and release high together after edge %0d, required exclusive", edgeIdx - 1);
      end
      if (press_pulse)   matchStrobe(0);
      if (release_pulse) matchStrobe(1);
      if (long_pulse)    matchStrobe(2);
    end
  end

  task automatic applyStimulus(input logic b);
    btn = b;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expVal);
    logic [3:0] act;
    act = {btn_level, press_pulse, release_pulse, long_pulse};
    numChecks++;
    if (act !== expVal) begin
      numErrors++;
      $display("[TB] FAIL %s: got level/press/release/long=%b, required %b", name, act, expVal);
    end
  endtask

  initial begin
    int e0;

    // Reset with the button chattering: nothing may come out.
    rst_n = 1'b0;
    btn   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      applyStimulus(i[0]);
    end
    checkOutput("reset_state", 4'b0000);
    @(negedge clk);
    applyStimulus(1'b0);
    #2 rst_n = 1'b1;
    waitCycles(5);
    checkOutput("after_reset", 4'b0000);

    // Bounce every 5 cycles for 60 cycles: never stable long enough.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(i % 2 == 0);
      waitCycles(5);
    end
    applyStimulus(1'b0);
    waitCycles(40);
    checkOutput("bounce_no_press", 4'b0000);

    // Clean press held 200 cycles: press after edge 22, long after edge 122.
    e0 = edgeIdx;
    applyStimulus(1'b1);
    pushExpect(0, e0 + DB_CYC + 2);
`ifdef BTN_LONG_PRESS_EN
    pushExpect(2, e0 + DB_CYC + 2 + LONG_CYC);
`endif
    waitCycles(22);
    checkOutput("press_edge21", 4'b0000);
    waitCycles(1);
    checkOutput("press_edge22", 4'b1100);
    waitCycles(1);
    checkOutput("press_edge23", 4'b1000);
    waitCycles(176);
    checkOutput("press_held", 4'b1000);

    // Release with a 10-cycle glitch at edge 15: release 22 edges after it ends.
    e0 = edgeIdx;
    applyStimulus(1'b0);
    waitCycles(15);
    applyStimulus(1'b1);
    waitCycles(5);
    checkOutput("glitch_mid", 4'b1000);
    waitCycles(5);
    applyStimulus(1'b0);
    pushExpect(1, e0 + 25 + DB_CYC + 2);
    waitCycles(22);
    checkOutput("release_edge46", 4'b1000);
    waitCycles(1);
    checkOutput("release_edge47", 4'b0010);
    waitCycles(30);
    checkOutput("released_idle", 4'b0000);

    // Reset at cycle 40 of a held press: no release, fresh press afterwards.
    e0 = edgeIdx;
    applyStimulus(1'b1);
    pushExpect(0, e0 + DB_CYC + 2);
    waitCycles(40);
    checkOutput("held_before_reset", 4'b1000);
    #2 rst_n = 1'b0;
    #1 checkOutput("reset_at_once", 4'b0000);
    waitCycles(3);
    #2 rst_n = 1'b1;
    e0 = edgeIdx;
    pushExpect(0, e0 + DB_CYC + 2);
    waitCycles(22);
    checkOutput("repress_edge21", 4'b0000);
    waitCycles(1);
    checkOutput("repress_edge22", 4'b1100);

    // Final clean release.
    e0 = edgeIdx;
    applyStimulus(1'b0);
    pushExpect(1, e0 + DB_CYC + 2);
    waitCycles(40);
    checkOutput("final_idle", 4'b0000);

    numChecks++;
    if (expQ.size() != 0) begin
      numErrors++;
      $display("[TB] FAIL missing_strobes: %0d still pending, required 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter CLK_HZ, default 125000000: clock frequency in Hz; SHALL be a multiple of 1000.
REQ-002 Parameter DEBOUNCE_MS, default 20: required stable time in ms; DB_CYC = (CLK_HZ/1000)*DEBOUNCE_MS SHALL be >= 2.
REQ-003 Parameter LONG_MS, default 1000: long-press threshold in ms; LONG_CYC = (CLK_HZ/1000)*LONG_MS SHALL be >= 2.
REQ-004 clk  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 btn  input  1  raw, asynchronous, bouncing button, active-high.
REQ-007 btn_level  output  1  debounced button state, 1 = pressed.
REQ-008 press_pulse  output  1  one-cycle strobe on a debounced press.
REQ-009 release_pulse  output  1  one-cycle strobe on a debounced release.
REQ-010 long_pulse  output  1  one-cycle strobe when a press has been held for LONG_CYC cycles.

Function
REQ-011 btn SHALL pass through a 2-flop synchronizer; btn_sync is the second flop's output; no other logic SHALL sample btn.
REQ-012 The FSM SHALL have exactly four states: IDLE (stable released), PRESS_WAIT, PRESSED (stable pressed), RELEASE_WAIT.
REQ-013 IDLE: btn_sync=1 -> PRESS_WAIT with db_cnt=0; otherwise stay.
REQ-014 PRESS_WAIT: btn_sync=0 -> IDLE, db_cnt=0, no strobe; btn_sync=1 and db_cnt<DB_CYC-1 -> db_cnt+1; btn_sync=1 and db_cnt=DB_CYC-1 -> PRESSED.
REQ-015 PRESSED: btn_sync=0 -> RELEASE_WAIT with db_cnt=0; otherwise stay.
REQ-016 RELEASE_WAIT: btn_sync=1 -> PRESSED, no strobe; btn_sync=0 and db_cnt<DB_CYC-1 -> db_cnt+1; btn_sync=0 and db_cnt=DB_CYC-1 -> IDLE.
REQ-017 All outputs SHALL be registered; press_pulse/release_pulse SHALL be high for exactly the one cycle following the edge on which PRESS_WAIT->PRESSED or RELEASE_WAIT->IDLE is taken.
REQ-018 btn_level SHALL be 1 in PRESSED and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT, and SHALL update on the same edge as the strobes.
REQ-019 Latency: btn changes and stays stable before edge 0 -> strobe and btn_level change after edge DB_CYC+2 (2 synchronizer + 1 detect + DB_CYC-1 count).
REQ-020 Any reversal during a WAIT state SHALL restart the full DB_CYC count on the next attempt; partial counts SHALL NOT accumulate.
REQ-021 db_cnt width SHALL be $clog2(DB_CYC) bits; db_cnt SHALL never exceed DB_CYC-1 and SHALL never wrap.
REQ-022 press_pulse and release_pulse SHALL never be high in the same cycle, and SHALL strictly alternate starting with press_pulse.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, synchronizer flops=0, all counters=0, all outputs=0, independent of clk.
REQ-024 Reset asserted mid-press SHALL produce no release_pulse; if btn is held through reset release, a press SHALL be detected DB_CYC+2 edges after the first post-reset edge.

Configuration
REQ-025 Macro BTN_LONG_PRESS_EN defined: long_cnt ($clog2(LONG_CYC) bits) SHALL clear on PRESS_WAIT->PRESSED, increment each cycle in PRESSED, hold in RELEASE_WAIT, and saturate; long_pulse SHALL fire once, after the edge where long_cnt=LONG_CYC-1 in PRESSED, i.e. LONG_CYC edges after press_pulse's edge.
REQ-026 With BTN_LONG_PRESS_EN defined, long_pulse SHALL fire at most once per press; a RELEASE_WAIT bounce back to PRESSED SHALL neither re-fire it nor clear long_cnt.
REQ-027 Macro BTN_LONG_PRESS_EN undefined: long_pulse SHALL be constant 0 and no long-press counter SHALL be synthesized.

Verification (CLK_HZ=10000, DEBOUNCE_MS=2 -> DB_CYC=20, LONG_MS=10 -> LONG_CYC=100)
REQ-028 rst_n=0 with btn toggling -> all outputs 0 throughout reset, no strobe.
REQ-029 btn toggles 1/0 every 5 cycles for 60 cycles then stays 0 -> no strobe, btn_level stays 0.
REQ-030 btn goes 1 before edge 0 and is held 60 cycles -> press_pulse high for exactly one cycle after edge 22, btn_level=1 from edge 22.
REQ-031 btn then goes 0 before edge 0 -> release_pulse high for one cycle after edge 22, btn_level=0; a 10-cycle glitch to 1 at edge 15 delays release_pulse to 22 edges after the glitch ends.
REQ-032 BTN_LONG_PRESS_EN defined, btn held 200 cycles -> press_pulse after edge 22, exactly one long_pulse after edge 122; macro undefined -> long_pulse never high.
REQ-033 rst_n pulsed low at cycle 40 of a held press -> outputs 0 at once, no release_pulse; btn still held -> press_pulse again 22 edges after reset release.
